// File: rtl/pic_pkg.sv
// Shared definitions for the parametrised 8259A-style priority resolver.
// OCW2 command codes, acknowledge states and the rotating rank helper.
package pic_pkg;

  localparam logic [2:0] CMD_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] CMD_NSEOI        = 3'b001;
  localparam logic [2:0] CMD_NOP          = 3'b010;
  localparam logic [2:0] CMD_SEOI         = 3'b011;
  localparam logic [2:0] CMD_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] CMD_ROT_NSEOI    = 3'b101;
  localparam logic [2:0] CMD_SET_PRIO     = 3'b110;
  localparam logic [2:0] CMD_ROT_SEOI     = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    ACK1 = 1'b1
  } ack_state_t;

  // Rank 0 is the line just above 'low'; no modulo so n need not be 2^k.
  function automatic int prio_rank(int i, int low, int n);
    int s;
    s = (low + 1 >= n) ? 0 : low + 1;
    return (i >= s) ? i - s : i + n - s;
  endfunction

endpackage

// File: rtl/pic_prio_select.sv
// Rotating priority encoder: picks the set request with the smallest rank.
// Rank is measured from the line just above 'lowest'.
module pic_prio_select
  import pic_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] lowest,
  output logic          found,
  output logic [IW-1:0] idx
);

  int best;
  int r;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = N;
    r     = 0;
    for (int i = 0; i < N; i++) begin
      r = prio_rank(i, int'(lowest), N);
      if (req[i] && r < best) begin
        best  = r;
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pic_priority_resolver_n.sv
// Parametrised 8259A-style priority resolver: IRR/IMR/ISR, rotating
// priority, OCW1/OCW2 handling and the two-pulse INTA acknowledge.
module pic_priority_resolver_n
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] ir,
  input  logic               ltim,
  input  logic               aeoi,
  input  logic               ocw1_wr,
  input  logic [NUM_IRQ-1:0] ocw1_data,
  input  logic               ocw2_wr,
  input  logic [2:0]         ocw2_cmd,
  input  logic [IDX_W-1:0]   ocw2_level,
  input  logic               inta_n,
  output logic               int_o,
  output logic [IDX_W-1:0]   int_vec,
  output logic               vec_valid,
  output logic               spurious,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [NUM_IRQ-1:0] imr
);

  localparam logic [IDX_W:0]   NUM_L = (IDX_W + 1)'(NUM_IRQ);
  localparam logic [IDX_W-1:0] TOP_L = IDX_W'(NUM_IRQ - 1);

  ack_state_t          state;
  logic [IDX_W-1:0]    lowest;
  logic                rot_aeoi;
  logic [NUM_IRQ-1:0]  ir_d;
  logic                inta_d;
  logic [IDX_W-1:0]    w_q;
  logic                spur_q;

  logic                hfound;
  logic [IDX_W-1:0]    hidx;
  logic                wfound;
  logic [IDX_W-1:0]    widx;
  logic [NUM_IRQ-1:0]  elig;
  int                  isr_rank;

  logic                fall;
  logic                lvl_ok;
  logic [NUM_IRQ-1:0]  isr_set;
  logic [NUM_IRQ-1:0]  isr_clr;
  logic [NUM_IRQ-1:0]  irr_clr;
  logic [NUM_IRQ-1:0]  irr_n;
  logic [NUM_IRQ-1:0]  isr_n;
  logic [IDX_W-1:0]    low_n;
  logic                rot_n;

  pic_prio_select #(.N(NUM_IRQ), .IW(IDX_W)) u_hsel (
    .req    (isr),
    .lowest (lowest),
    .found  (hfound),
    .idx    (hidx)
  );

  always_comb begin
    isr_rank = hfound ? prio_rank(int'(hidx), int'(lowest), NUM_IRQ)
                      : NUM_IRQ;
    elig = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      elig[i] = irr[i] & ~imr[i]
              & (prio_rank(i, int'(lowest), NUM_IRQ) < isr_rank);
    end
  end

  pic_prio_select #(.N(NUM_IRQ), .IW(IDX_W)) u_wsel (
    .req    (elig),
    .lowest (lowest),
    .found  (wfound),
    .idx    (widx)
  );

  assign int_o  = wfound;
  assign fall   = inta_d & ~inta_n;
  assign lvl_ok = {1'b0, ocw2_level} < NUM_L;

  always_comb begin
    isr_set = '0;
    isr_clr = '0;
    irr_clr = '0;
    low_n   = lowest;
    rot_n   = rot_aeoi;
    if (ocw2_wr && lvl_ok) begin
      case (ocw2_cmd)
        CMD_NSEOI: if (hfound) isr_clr[hidx] = 1'b1;
        CMD_SEOI:  isr_clr[ocw2_level] = 1'b1;
        CMD_ROT_NSEOI: begin
          if (hfound) begin
            isr_clr[hidx] = 1'b1;
            low_n = hidx;
          end
        end
        CMD_ROT_SEOI: begin
          isr_clr[ocw2_level] = 1'b1;
          low_n = ocw2_level;
        end
        CMD_SET_PRIO:     low_n = ocw2_level;
        CMD_ROT_AEOI_SET: rot_n = 1'b1;
        CMD_ROT_AEOI_CLR: rot_n = 1'b0;
        default: ;
      endcase
    end
    if (fall && state == IDLE && wfound) begin
      isr_set[widx] = 1'b1;
      if (!ltim) irr_clr[widx] = 1'b1;
    end
    if (fall && state == ACK1 && aeoi && !spur_q) begin
      isr_clr[w_q] = 1'b1;
      if (rot_aeoi) low_n = w_q;
    end
    // A fresh edge on the acknowledged bit re-raises it.
    irr_n = ltim ? ir : ((irr & ~irr_clr) | (ir & ~ir_d));
    isr_n = (isr & ~isr_clr) | isr_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irr       <= '0;
      isr       <= '0;
      imr       <= '1;
      lowest    <= TOP_L;
      rot_aeoi  <= 1'b0;
      ir_d      <= '0;
      inta_d    <= 1'b1;
      state     <= IDLE;
      w_q       <= '0;
      spur_q    <= 1'b0;
      int_vec   <= '0;
      vec_valid <= 1'b0;
      spurious  <= 1'b0;
    end else begin
      irr       <= irr_n;
      isr       <= isr_n;
      lowest    <= low_n;
      rot_aeoi  <= rot_n;
      ir_d      <= ir;
      inta_d    <= inta_n;
      vec_valid <= 1'b0;
      spurious  <= 1'b0;
      if (ocw1_wr) imr <= ocw1_data;
      case (state)
        IDLE: begin
          if (fall) begin
            state  <= ACK1;
            w_q    <= widx;
            spur_q <= ~wfound;
          end
        end
        ACK1: begin
          if (fall) begin
            state     <= IDLE;
            int_vec   <= spur_q ? TOP_L : w_q;
            vec_valid <= 1'b1;
            spurious  <= spur_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_priority_resolver_n.sv
// Directed bench for pic_priority_resolver_n with NUM_IRQ=8.
// Hand-computed expectations checked with immediate assertions.
module tb_pic_priority_resolver_n;

  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  ir;
  logic          ltim;
  logic          aeoi;
  logic          ocw1_wr;
  logic [N-1:0]  ocw1_data;
  logic          ocw2_wr;
  logic [2:0]    ocw2_cmd;
  logic [IW-1:0] ocw2_level;
  logic          inta_n;
  logic          int_o;
  logic [IW-1:0] int_vec;
  logic          vec_valid;
  logic          spurious;
  logic [N-1:0]  irr;
  logic [N-1:0]  isr;
  logic [N-1:0]  imr;

  int checks = 0;
  int errors = 0;
  logic vv;
  logic sp;

  always #5 clk = ~clk;

  pic_priority_resolver_n #(.NUM_IRQ(N), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ir         (ir),
    .ltim       (ltim),
    .aeoi       (aeoi),
    .ocw1_wr    (ocw1_wr),
    .ocw1_data  (ocw1_data),
    .ocw2_wr    (ocw2_wr),
    .ocw2_cmd   (ocw2_cmd),
    .ocw2_level (ocw2_level),
    .inta_n     (inta_n),
    .int_o      (int_o),
    .int_vec    (int_vec),
    .vec_valid  (vec_valid),
    .spurious   (spurious),
    .irr        (irr),
    .isr        (isr),
    .imr        (imr)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_ir(input logic [N-1:0] m);
    ir = m;
    tick(1);
    ir = '0;
    tick(1);
  endtask

  task automatic wr1(input logic [N-1:0] d);
    ocw1_wr = 1'b1;
    ocw1_data = d;
    tick(1);
    ocw1_wr = 1'b0;
  endtask

  task automatic wr2(input logic [2:0] c, input logic [IW-1:0] l);
    ocw2_wr = 1'b1;
    ocw2_cmd = c;
    ocw2_level = l;
    tick(1);
    ocw2_wr = 1'b0;
  endtask

  task automatic inta(output logic v, output logic s);
    inta_n = 1'b0;
    tick(1);
    v = vec_valid;
    s = spurious;
    inta_n = 1'b1;
    tick(1);
  endtask

  task automatic ack(input string tag, input int ev, input logic es);
    logic v1, s1, v2, s2;
    inta(v1, s1);
    inta(v2, s2);
    chk({tag, "_vv"}, 32'(v2), 32'd1);
    chk({tag, "_vec"}, 32'(int_vec), 32'(ev));
    chk({tag, "_sp"}, 32'(s2), 32'(es));
  endtask

  initial begin
    rst_n = 1'b0;
    ir = '0;
    ltim = 1'b0;
    aeoi = 1'b0;
    ocw1_wr = 1'b0;
    ocw1_data = '0;
    ocw2_wr = 1'b0;
    ocw2_cmd = 3'b010;
    ocw2_level = '0;
    inta_n = 1'b1;
    tick(2);
    chk("rst_irr", 32'(irr), 32'h00);
    chk("rst_isr", 32'(isr), 32'h00);
    chk("rst_imr", 32'(imr), 32'hFF);
    chk("rst_vec", 32'(int_vec), 32'd0);
    chk("rst_vv", 32'(vec_valid), 32'd0);
    chk("rst_int", 32'(int_o), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Fully nested, two simultaneous edges
    wr1(8'h00);
    chk("t1_imr", 32'(imr), 32'h00);
    pulse_ir(8'h28);
    chk("t1_irr", 32'(irr), 32'h28);
    chk("t1_int", 32'(int_o), 32'd1);
    ack("t1_ack", 3, 1'b0);
    chk("t1_isr", 32'(isr), 32'h08);
    chk("t1_irr2", 32'(irr), 32'h20);
    chk("t1_int0", 32'(int_o), 32'd0);
    wr2(3'b001, 3'd0);
    chk("t1_eoi_isr", 32'(isr), 32'h00);
    chk("t1_eoi_int", 32'(int_o), 32'd1);
    ack("t1_ack5", 5, 1'b0);
    wr2(3'b001, 3'd0);
    chk("t1_clean", 32'(isr | irr), 32'h00);

    // Mask then unmask
    wr1(8'h08);
    pulse_ir(8'h08);
    chk("t2_irr", 32'(irr), 32'h08);
    chk("t2_int0", 32'(int_o), 32'd0);
    wr1(8'h00);
    chk("t2_int1", 32'(int_o), 32'd1);
    ack("t2_ack", 3, 1'b0);
    wr2(3'b001, 3'd0);

    // Specific priority and rotate on specific EOI
    wr2(3'b110, 3'd4);
    pulse_ir(8'h44);
    ack("t3_ack6", 6, 1'b0);
    chk("t3_isr", 32'(isr), 32'h40);
    wr2(3'b111, 3'd6);
    chk("t3_isr0", 32'(isr), 32'h00);
    pulse_ir(8'h20);
    chk("t3_irr", 32'(irr), 32'h24);
    ack("t3_ack2", 2, 1'b0);
    wr2(3'b001, 3'd0);
    ack("t3_ack5", 5, 1'b0);
    wr2(3'b001, 3'd0);
    wr2(3'b110, 3'd7);

    // Automatic EOI with rotation
    aeoi = 1'b1;
    wr2(3'b100, 3'd0);
    pulse_ir(8'h02);
    ack("t4_ack1", 1, 1'b0);
    chk("t4_isr", 32'(isr), 32'h00);
    pulse_ir(8'h05);
    ack("t4_ack2", 2, 1'b0);
    ack("t4_ack0", 0, 1'b0);
    chk("t4_isr2", 32'(isr), 32'h00);
    wr2(3'b000, 3'd0);
    aeoi = 1'b0;
    wr2(3'b110, 3'd7);

    // Spurious acknowledge
    ack("t5_spur", 7, 1'b1);
    chk("t5_isr", 32'(isr), 32'h00);

    // Level mode
    ltim = 1'b1;
    ir = 8'h01;
    tick(1);
    chk("t6_irr", 32'(irr), 32'h01);
    ack("t6_ack", 0, 1'b0);
    chk("t6_isr", 32'(isr), 32'h01);
    chk("t6_int0", 32'(int_o), 32'd0);
    wr2(3'b001, 3'd0);
    chk("t6_irr2", 32'(irr), 32'h01);
    chk("t6_int1", 32'(int_o), 32'd1);
    ir = 8'h00;
    tick(1);
    chk("t6_drop", 32'(irr), 32'h00);
    ltim = 1'b0;
    tick(1);

    // Reset between the two acknowledge pulses
    pulse_ir(8'h10);
    inta(vv, sp);
    chk("t7_isr1", 32'(isr), 32'h10);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_isr", 32'(isr), 32'h00);
    chk("t7_rst_imr", 32'(imr), 32'hFF);
    chk("t7_rst_irr", 32'(irr), 32'h00);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    wr1(8'h00);
    pulse_ir(8'h10);
    inta(vv, sp);
    chk("t7_first_vv", 32'(vv), 32'd0);
    chk("t7_first_isr", 32'(isr), 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_priority_resolver_n.md
Name: pic_priority_resolver_n

Overview:
- Synchronous, parametrised successor of the 8259A priority resolver.
- Holds IRR, IMR and ISR for NUM_IRQ request lines, with edge- or level-triggered capture.
- Resolves the winning request under fully-nested or rotating priority and runs the two-pulse INTA acknowledge sequence.
- Sits between the I/O request lines, the control logic (ICW/OCW decode) and the read/write logic. The control logic turns int_vec into the vector byte.

Parameters:
- NUM_IRQ, 8, number of interrupt request lines, 2..32.
- IDX_W, $clog2(NUM_IRQ), width of level/vector indices.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ir  in  NUM_IRQ  request lines, synchronous to clk.
- ltim  in  1  1 = level-triggered, 0 = edge-triggered (from ICW1).
- aeoi  in  1  automatic EOI enable (from ICW4).
- ocw1_wr  in  1  one-cycle strobe; load imr from ocw1_data.
- ocw1_data  in  NUM_IRQ  new mask.
- ocw2_wr  in  1  one-cycle strobe; execute ocw2_cmd.
- ocw2_cmd  in  3  {R,SL,EOI}.
- ocw2_level  in  IDX_W  level for specific commands.
- inta_n  in  1  CPU acknowledge, active low, synchronous.
- int_o  out  1  interrupt request to CPU.
- int_vec  out  IDX_W  acknowledged level.
- vec_valid  out  1  one-cycle pulse when int_vec is updated.
- spurious  out  1  one-cycle pulse with vec_valid when no request won.
- irr  out  NUM_IRQ  interrupt request register.
- isr  out  NUM_IRQ  in-service register.
- imr  out  NUM_IRQ  interrupt mask register.

Behaviour:
- Reset values: irr=0, isr=0, imr=all ones, int_vec=0, vec_valid=0, spurious=0, lowest=NUM_IRQ-1 (IR0 highest), rot_aeoi=0, state=IDLE, ir_d=0, inta_d=1.
- Priority rank:
  - rank(i) = (i - lowest - 1) mod NUM_IRQ; rank 0 is highest.
  - Computed with compare/subtract; NUM_IRQ need not be a power of two.
- Capture:
  - Edge mode: irr[i] is set in the cycle after ir[i]=1 and ir_d[i]=0.
  - Level mode: irr <= ir every cycle.
- int_o is combinational from registers: 1 iff some i has irr[i] & ~imr[i] and rank(i) is lower than the rank of every set isr bit.
- Acknowledge FSM, stepping on an inta_n falling edge (inta_d=1, inta_n=0):
  - IDLE -> ACK1 on the first edge. Latch winner w = min-rank i with irr[i]&~imr[i] and rank below the highest ISR rank.
    - If a winner exists: set isr[w]; in edge mode clear irr[w].
    - If none: mark the sequence spurious; ISR unchanged.
  - ACK1 -> IDLE on the second edge.
    - Drive int_vec=w, or NUM_IRQ-1 if spurious; pulse vec_valid, and pulse spurious if applicable.
    - If aeoi and not spurious: clear isr[w]; if rot_aeoi also set, lowest<=w.
- OCW2 commands:
  - 001 non-specific EOI: clear the min-rank set isr bit.
  - 011 specific EOI: clear isr[level].
  - 101 rotate on non-specific EOI: clear the min-rank isr bit h; lowest<=h.
  - 111 rotate on specific EOI: clear isr[level]; lowest<=level.
  - 110 set priority: lowest<=level.
  - 100 set rot_aeoi.
  - 000 clear rot_aeoi.
  - 010 no-op.
  - EOI with no ISR bit set: no change.
  - ocw2_level >= NUM_IRQ: the command is ignored.
- Simultaneous events:
  - New edge on bit w in the same cycle it is cleared by ack: irr[w] stays 1.
  - ISR set and EOI clear on the same bit in the same cycle: set wins.
  - OCW1 or OCW2 in the same cycle as the first edge: the winner uses the pre-write imr/lowest.
- Register update latency: 1 cycle for all register updates.
- Reset mid-sequence: immediate return to IDLE with all reset values.

Decomposition:
- pic_pkg holds:
  - OCW2 command localparams: CMD_NSEOI, CMD_SEOI, CMD_ROT_NSEOI, CMD_ROT_SEOI, CMD_SET_PRIO, CMD_ROT_AEOI_SET, CMD_ROT_AEOI_CLR.
  - The ack state enum {IDLE, ACK1}.
- One sub-module, pic_prio_select: combinational rotating priority encoder.
  - Inputs: request vector, lowest.
  - Outputs: found, index.
  - Instantiated twice: once for the winner, once for the highest ISR.

Test Plan:
- NUM_IRQ=8, edge mode, imr=0x00; pulse ir[3] and ir[5] in the same cycle -> int_o=1. Two inta_n pulses -> isr=0x08, irr=0x20, int_vec=3, vec_valid pulse, int_o=0. Non-specific EOI -> isr=0x00, int_o=1.
- imr=0x08, pulse ir[3] -> irr=0x08, int_o=0. Write imr=0x00 -> int_o=1 next cycle.
- Set priority level=4, ir[2] and ir[6] pending -> acknowledge gives int_vec=6. Rotate on specific EOI level 6 -> lowest=6, and the next ack picks 2 over later-raised ir[5].
- aeoi=1, rot_aeoi set, ack ir[1] -> isr=0x00 after the second pulse, lowest=1, int_vec=1.
- inta_n pulses with irr=0 -> int_vec=7, spurious pulse, isr=0x00.
- Level mode, ir[0] held high: ack then EOI -> irr[0]=1 and int_o re-asserts. Drop ir[0] -> irr=0x00 next cycle.
- Assert rst_n=0 between the two inta_n pulses -> state IDLE, isr=0x00, imr=0xFF. The next single pulse is treated as a first pulse.
